// File: rtl/immed_pack.sv
// immed_pack
//
// Packs decoded RV32I instruction fields and a full 32-bit signed immediate
// into one 32-bit instruction word. It is the inverse of the core's immediate
// extraction. It also flags immediates that the target format cannot
// represent, and opcodes it does not handle.
//
// Pipeline: two stages with valid/ready flow control.
//   stage 1 : registers the fields, the format select and the range-check result
//   stage 2 : registers the packed word (inst) and its err flag
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request valid
//   in_ready   out  block can accept a request this cycle
//   opcode     in   target opcode (7 bits)
//   rd         in   destination register field
//   rs1        in   source 1 field
//   rs2        in   source 2 field
//   funct3     in   funct3 field
//   funct7     in   funct7 field, used by R-type only
//   immed      in   signed immediate; a byte offset for branch and jump
//   out_valid  out  packed word valid
//   out_ready  in   consumer accepts the word
//   inst       out  packed instruction word
//   err        out  immediate unrepresentable or opcode unsupported; qualifies inst
//   err_count  out  saturating count of delivered words that had err=1

module immed_pack #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           opcode,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [31:0]          immed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          inst,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef logic [31:0] word_t;

  localparam logic [6:0] ISA_OPCODE_LOAD     = 7'h03;
  localparam logic [6:0] ISA_OPCODE_OP_IMMED = 7'h13;
  localparam logic [6:0] ISA_OPCODE_AUIPC    = 7'h17;
  localparam logic [6:0] ISA_OPCODE_STORE    = 7'h23;
  localparam logic [6:0] ISA_OPCODE_OP       = 7'h33;
  localparam logic [6:0] ISA_OPCODE_LUI      = 7'h37;
  localparam logic [6:0] ISA_OPCODE_BRANCH   = 7'h63;
  localparam logic [6:0] ISA_OPCODE_JALR     = 7'h67;
  localparam logic [6:0] ISA_OPCODE_JAL      = 7'h6F;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_R,
    FMT_X
  } fmt_e;

  // Stage 1 state
  logic        s1_valid;
  fmt_e        s1_fmt;
  logic        s1_err;
  logic [6:0]  s1_opcode;
  logic [4:0]  s1_rd;
  logic [4:0]  s1_rs1;
  logic [4:0]  s1_rs2;
  logic [2:0]  s1_funct3;
  logic [6:0]  s1_funct7;
  word_t       s1_immed;

  // Stage 2 state (drives the outputs directly)
  logic        s2_valid;

  // Combinational helpers
  fmt_e        fmt_in;
  logic        err_in;
  word_t       pack_word;
  logic        s1_load;
  logic        s2_load;
  logic        out_xfer;

  // An immediate fits the format when every bit above the format's sign bit
  // copies that sign bit, i.e. the upper slice is all zeros or all ones.
  logic        fits_is;
  logic        fits_b;
  logic        fits_j;

  assign fits_is = (immed[31:11] == '0) || (immed[31:11] == '1);
  assign fits_b  = (immed[31:12] == '0) || (immed[31:12] == '1);
  assign fits_j  = (immed[31:20] == '0) || (immed[31:20] == '1);

  // Stage 2 can take a new word when it is empty or its word leaves this
  // cycle. Stage 1 can take a new request when it is empty or moves forward
  // this cycle. Because of that, a full pipe still streams one word per cycle.
  assign s2_load  = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign s1_load  = in_valid && in_ready;
  assign out_xfer = s2_valid && out_ready;

  assign out_valid = s2_valid;

  // Format decode and range check on the incoming request
  always_comb begin
    fmt_in = FMT_X;
    err_in = 1'b1;
    unique case (opcode)
      ISA_OPCODE_LOAD, ISA_OPCODE_OP_IMMED, ISA_OPCODE_JALR: begin
        fmt_in = FMT_I;
        err_in = !fits_is;
      end
      ISA_OPCODE_STORE: begin
        fmt_in = FMT_S;
        err_in = !fits_is;
      end
      ISA_OPCODE_BRANCH: begin
        fmt_in = FMT_B;
        err_in = !fits_b || immed[0];
      end
      ISA_OPCODE_LUI, ISA_OPCODE_AUIPC: begin
        fmt_in = FMT_U;
        err_in = (immed[11:0] != 12'h000);
      end
      ISA_OPCODE_JAL: begin
        fmt_in = FMT_J;
        err_in = !fits_j || immed[0];
      end
      ISA_OPCODE_OP: begin
        fmt_in = FMT_R;
        err_in = 1'b0;
      end
      default: begin
        fmt_in = FMT_X;
        err_in = 1'b1;
      end
    endcase
  end

  // Bit scatter of the stage 1 fields into the RV32I layouts. An out-of-range
  // immediate is simply truncated. The err flag carries the problem downstream.
  always_comb begin
    pack_word = '0;
    unique case (s1_fmt)
      FMT_I: pack_word = {s1_immed[11:0], s1_rs1, s1_funct3, s1_rd, s1_opcode};
      FMT_S: pack_word = {s1_immed[11:5], s1_rs2, s1_rs1, s1_funct3,
                          s1_immed[4:0], s1_opcode};
      FMT_B: pack_word = {s1_immed[12], s1_immed[10:5], s1_rs2, s1_rs1, s1_funct3,
                          s1_immed[4:1], s1_immed[11], s1_opcode};
      FMT_U: pack_word = {s1_immed[31:12], s1_rd, s1_opcode};
      FMT_J: pack_word = {s1_immed[20], s1_immed[10:1], s1_immed[11],
                          s1_immed[19:12], s1_rd, s1_opcode};
      FMT_R: pack_word = {s1_funct7, s1_rs2, s1_rs1, s1_funct3, s1_rd, s1_opcode};
      default: pack_word = '0;
    endcase
  end

  // Stage 1 register: captures the request only on an input transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_fmt    <= FMT_X;
      s1_err    <= 1'b0;
      s1_opcode <= '0;
      s1_rd     <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_funct3 <= '0;
      s1_funct7 <= '0;
      s1_immed  <= '0;
    end else if (s1_load) begin
      s1_valid  <= 1'b1;
      s1_fmt    <= fmt_in;
      s1_err    <= err_in;
      s1_opcode <= opcode;
      s1_rd     <= rd;
      s1_rs1    <= rs1;
      s1_rs2    <= rs2;
      s1_funct3 <= funct3;
      s1_funct7 <= funct7;
      s1_immed  <= immed;
    end else if (s2_load) begin
      s1_valid  <= 1'b0;
    end
  end

  // Stage 2 register: inst/err change only when a new word loads, so they
  // hold steady while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      inst     <= '0;
      err      <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      inst     <= pack_word;
      err      <= s1_err;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // Error counter: counts delivered err words and sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (out_xfer && err && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_immed_pack.sv
// tb_immed_pack
//
// Randomised and directed bench for immed_pack. The driver pushes the
// expected word for every accepted request into a scoreboard queue. A
// separate monitor pops and compares on every output transfer. The expected
// words come from a reference model that works from immediate value ranges
// and the ISA field layout.

module tb_immed_pack;

  localparam int ERR_CNT_W = 16;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMMED  = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OP     = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [6:0]           opcode;
  logic [4:0]           rd;
  logic [4:0]           rs1;
  logic [4:0]           rs2;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic [31:0]          immed;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          inst;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_count;

  typedef struct {
    logic [31:0] word;
    logic        e;
    bit          lat_chk;
    int          acc_cyc;
  } exp_t;

  exp_t q[$];

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  n_out = 0;
  int  model_cnt = 0;
  bit  mon_en = 0;
  bit  rand_ready = 0;

  immed_pack #(.ERR_CNT_W(ERR_CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .immed     (immed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inst      (inst),
    .err       (err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference model: decide representability from the numeric range of the
  // immediate, then place the bits where the ISA puts them.
  function automatic void refModel(input logic [6:0] op, input logic [4:0] f_rd,
                                   input logic [4:0] f_rs1, input logic [4:0] f_rs2,
                                   input logic [2:0] f_f3, input logic [6:0] f_f7,
                                   input logic [31:0] imm,
                                   output logic [31:0] w, output logic e);
    longint v;
    logic [31:0] op32, rd32, rs1w, rs2w, f3w, f7w;
    v    = longint'($signed(imm));
    op32 = 32'(op);
    rd32 = 32'(f_rd) << 7;
    rs1w = 32'(f_rs1) << 15;
    rs2w = 32'(f_rs2) << 20;
    f3w  = 32'(f_f3) << 12;
    f7w  = 32'(f_f7) << 25;
    w = 32'h0;
    e = 1'b1;
    case (op)
      OP_LOAD, OP_IMMED, OP_JALR: begin
        e = !(v >= -2048 && v <= 2047);
        w = ((imm & 32'hFFF) << 20) | rs1w | f3w | rd32 | op32;
      end
      OP_STORE: begin
        e = !(v >= -2048 && v <= 2047);
        w = (((imm >> 5) & 32'h7F) << 25) | rs2w | rs1w | f3w |
            ((imm & 32'h1F) << 7) | op32;
      end
      OP_BRANCH: begin
        e = !(v >= -4096 && v <= 4095) || ((imm % 2) != 0);
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
            rs2w | rs1w | f3w | (((imm >> 1) & 32'hF) << 8) |
            (((imm >> 11) & 32'h1) << 7) | op32;
      end
      OP_LUI, OP_AUIPC: begin
        e = ((imm % 4096) != 0);
        w = (imm & 32'hFFFF_F000) | rd32 | op32;
      end
      OP_JAL: begin
        e = !(v >= -(64'sd1 << 20) && v <= (64'sd1 << 20) - 1) || ((imm % 2) != 0);
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
            (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
            rd32 | op32;
      end
      OP_OP: begin
        e = 1'b0;
        w = f7w | rs2w | rs1w | f3w | rd32 | op32;
      end
      default: begin
        e = 1'b1;
        w = 32'h0;
      end
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual,
               expected, $time);
    end
  endtask

  // Offer one request and wait (bounded) for it to be accepted. The task is
  // entered at a falling edge and returns at the falling edge after the
  // accepting rising edge.
  task automatic applyStimulus(input logic [6:0] op, input logic [4:0] f_rd,
                               input logic [4:0] f_rs1, input logic [4:0] f_rs2,
                               input logic [2:0] f_f3, input logic [6:0] f_f7,
                               input logic [31:0] imm, input bit lat_chk);
    exp_t ent;
    bit   accepted = 0;
    opcode   = op;
    rd       = f_rd;
    rs1      = f_rs1;
    rs2      = f_rs2;
    funct3   = f_f3;
    funct7   = f_f7;
    immed    = imm;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_ready) begin
        refModel(op, f_rd, f_rs1, f_rs2, f_f3, f_f7, imm, ent.word, ent.e);
        ent.lat_chk = lat_chk;
        ent.acc_cyc = cyc + 1;
        q.push_back(ent);
        accepted = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 500 && q.size() != 0; t++) @(negedge clk);
    @(negedge clk);
    checkOutput("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask

  // Monitor: samples 2 ns after each falling edge, when the inputs driven at
  // the falling edge have settled, and looks ahead to the next rising edge.
  initial begin : monitor
    exp_t        ent;
    bit          prev_stall = 0;
    logic [31:0] prev_inst = '0;
    logic        prev_err = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!mon_en) begin
        prev_stall = 0;
      end else begin
        checkOutput("err_count", 32'(err_count), 32'(model_cnt));
        if (prev_stall) begin
          checkOutput("stall_valid", 32'(out_valid), 32'd1);
          checkOutput("stall_inst", inst, prev_inst);
          checkOutput("stall_err", 32'(err), 32'(prev_err));
        end
        if (out_valid && out_ready) begin
          n_out++;
          if (q.size() == 0) begin
            checkOutput("unexpected_output", inst, 32'hDEAD_BEEF);
          end else begin
            ent = q.pop_front();
            checkOutput("inst", inst, ent.word);
            checkOutput("err", 32'(err), 32'(ent.e));
            if (ent.lat_chk) checkOutput("latency", 32'(cyc + 1 - ent.acc_cyc), 32'd2);
            if (err && model_cnt < (1 << ERR_CNT_W) - 1) model_cnt++;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_inst  = inst;
        prev_err   = err;
      end
    end
  end

  initial begin : driver
    int n_before;
    logic [6:0] ops[10];
    ops = '{OP_LOAD, OP_IMMED, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI,
            OP_AUIPC, OP_JAL, OP_OP, 7'h7F};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; immed = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_inst", inst, 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_err_count", 32'(err_count), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    mon_en = 1;
    out_ready = 1'b1;

    $display("[TB] directed: addi, sw/beq back-to-back, lui, jal");
    applyStimulus(OP_IMMED, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1);
    applyStimulus(OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1);
    applyStimulus(OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1);
    applyStimulus(OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1);
    applyStimulus(OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1);
    drain();
    // Cross-check the model against hand-derived encodings.
    begin
      logic [31:0] w; logic e;
      refModel(OP_IMMED, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, w, e);
      checkOutput("model_addi", w, 32'hFFF0_0093);
      refModel(OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, w, e);
      checkOutput("model_beq", w, 32'hFE00_0EE3);
    end

    $display("[TB] directed: error cases");
    applyStimulus(OP_IMMED, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd2048, 0);
    applyStimulus(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'd6, 0);
    applyStimulus(OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd1, 7'd0, 32'd3, 0);
    applyStimulus(OP_LUI, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 0);
    applyStimulus(7'h7F, 5'd9, 5'd9, 5'd9, 3'd7, 7'd9, 32'd0, 0);
    drain();
    checkOutput("err_count_after_errors", 32'(err_count), 32'd4);

    $display("[TB] directed: backpressure");
    out_ready = 1'b0;
    applyStimulus(OP_OP, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0, 0);
    applyStimulus(OP_LOAD, 5'd6, 5'd7, 5'd0, 3'd2, 7'd0, 32'd100, 0);
    opcode = OP_STORE; rd = 5'd0; rs1 = 5'd8; rs2 = 5'd9; funct3 = 3'd2;
    funct7 = 7'd0; immed = 32'hFFFF_FFF0;
    in_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      #1;
      checkOutput("full_in_ready", 32'(in_ready), 32'd0);
      checkOutput("full_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    n_before = n_out;
    out_ready = 1'b1;
    applyStimulus(OP_STORE, 5'd0, 5'd8, 5'd9, 3'd2, 7'd0, 32'hFFFF_FFF0, 0);
    @(negedge clk);
    #3;
    checkOutput("burst_out_count", 32'(n_out - n_before), 32'd3);
    @(negedge clk);
    drain();

    $display("[TB] directed: reset with words in flight");
    out_ready = 1'b0;
    applyStimulus(OP_IMMED, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd5, 0);
    applyStimulus(OP_IMMED, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd6, 0);
    #3;
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_reset_err_count", 32'(err_count), 32'd0);
    q.delete();
    model_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #1;
      checkOutput("post_reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
    end
    mon_en = 1;

    $display("[TB] random stream");
    rand_ready = 1;
    for (int n = 0; n < 400; n++) begin
      logic [6:0]  op;
      logic [31:0] imm;
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      case ($urandom_range(0, 4))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 10000)) - 32'd5000;
        2: imm = $urandom << 12;
        3: imm = 32'($urandom_range(0, 4)) + 32'h000F_FFFD;
        default: imm = (32'($urandom_range(0, 16384)) - 32'd8192) & 32'hFFFF_FFFE;
      endcase
      applyStimulus(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                    7'($urandom), imm, 0);
      if ($urandom_range(0, 7) == 0) begin
        out_ready = ($urandom_range(0, 1) != 0);
        @(negedge clk);
      end
    end
    rand_ready = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/immed_pack.md
Name: immed_pack

Overview:
- Inverse of the core's immediate extraction: takes decoded instruction fields plus a full 32-bit signed immediate and packs them into a 32-bit RV32I instruction word.
- Validates that the immediate is representable in the target format.
- 2-stage valid/ready pipeline. Used by the boot loader/self-test sequencer and by verification stimulus generators to synthesise instruction streams on-chip.
- Opcode constants (ISA_OPCODE_*) and word_t come from types.sv.

Parameters:
ERR_CNT_W, 16, width of saturating error counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request this cycle
opcode  in  7  target opcode (ISA_OPCODE_*)
rd  in  5  destination register field
rs1  in  5  source 1 field
rs2  in  5  source 2 field
funct3  in  3  funct3 field
funct7  in  7  funct7 field (R-type only)
immed  in  32  signed immediate, byte offset for branch/jump
out_valid  out  1  packed word valid
out_ready  in  1  consumer accepts word
inst  out  32  packed instruction word
err  out  1  immediate unrepresentable or opcode unsupported; qualifies inst
err_count  out  ERR_CNT_W  saturating count of err words delivered

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, inst=0, err=0, err_count=0, in_ready=1 after release.
- Handshake: a transfer occurs on cycles where valid&ready are both high. Input fields are sampled only on in transfer. out_valid/inst/err are held stable while out_valid=1 and out_ready=0.
- Latency: 2 cycles from input transfer to out_valid with no backpressure. Throughput is 1 per cycle.
- Ordering: strict FIFO order, no drop, no duplication.
- Stage 1 registers the fields plus a format select:
  - I = LOAD, OP_IMMED, JALR
  - S = STORE
  - B = BRANCH
  - U = LUI, AUIPC
  - J = JAL
  - R = OP
  - X = anything else
- Stage 1 range check, setting err1:
  - I/S: immed[31:11] must be all equal.
  - B: immed[31:12] all equal, and immed[0]=0.
  - J: immed[31:20] all equal, and immed[0]=0.
  - U: immed[11:0]=0.
  - R: immed is ignored, no check.
  - X: always err.
- Stage 2 packs into the registered output:
  - I: {immed[11:0], rs1, funct3, rd, opcode}
  - S: {immed[11:5], rs2, rs1, funct3, immed[4:0], opcode}
  - B: {immed[12], immed[10:5], rs2, rs1, funct3, immed[4:1], immed[11], opcode}
  - U: {immed[31:12], rd, opcode}
  - J: {immed[20], immed[10:1], immed[11], immed[19:12], rd, opcode}
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - X: 32'h0
- On err, the word is still packed with truncated bits (except X) and delivered with err=1. It is never suppressed.
- Flow control:
  - s2 loads when s1_valid and (!s2_valid or out_ready).
  - s1 loads when in_valid and in_ready.
  - in_ready = !s1_valid or s1 advancing to s2 in the same cycle.
  - Full: both stages valid and out_ready=0 → in_ready=0.
  - Simultaneous in/out transfer when full is allowed: everything shifts, no bubble.
- err_count increments on each out transfer with err=1 and saturates at all-ones (no wrap).
- Reset mid-operation discards all in-flight words. No partial output appears after reset.

Test Plan:
- addi: opcode=OP_IMMED, rd=1, rs1=0, funct3=0, immed=-1 → inst=0xFFF00093, err=0, out_valid exactly 2 cycles after accept.
- sw and beq back-to-back, out_ready=1:
  - STORE rs1=1, rs2=2, funct3=2, immed=8 → inst=0x0020A423.
  - Then BRANCH rs1=0, rs2=0, funct3=0, immed=-4 → inst=0xFE000EE3, on consecutive cycles.
- U/J formats:
  - LUI rd=5, immed=0x12345000 → 0x123452B7.
  - JAL rd=1, immed=2048 → 0x001000EF.
  - Both with err=0.
- Errors:
  - OP_IMMED immed=2048 → err=1.
  - BRANCH immed=6 → err=0.
  - BRANCH immed=3 → err=1.
  - LUI immed=0x1 → err=1.
  - opcode=0x7F → inst=0, err=1.
  - After these, err_count=4.
- Backpressure: out_ready=0 while offering 3 requests → exactly 2 accepted, in_ready=0, inst stable. Raise out_ready → 3 words emerge in order, one per cycle.
- Reset: assert rst_n=0 with 2 words in flight → out_valid=0 and err_count=0 immediately (asynchronously). After release no stale words appear and in_ready=1.
